// File: rtl/msf_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : msf_sync_ctrl
// Purpose  : Lock/sequencing controller sitting between the MSF time/date
//            decoder and the digit display. Decoded minute frames only reach
//            the display after two consecutive frames one minute apart agree.
//            Once locked, matching frames re-sync the reference time. Bad or
//            missing frames are ridden through for up to MISS_LIMIT minute
//            windows before the controller drops back to UNLOCKED.
// Ports    : clk_i, rst_i (async, active low)
//            tick_i, minute_mark_i   : second pulse / minute mark (mark only
//                                      honoured together with tick_i)
//            frame_valid_i + hour/minute BCD fields from the decoder
//            load_o + hour/minute BCD load values to the digits block
//            locked_o, state_o, miss_cnt_o : status
// Revision : 1.0 - initial release
// ============================================================================
module msf_sync_ctrl #(
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tick_i,
  input  logic       minute_mark_i,
  input  logic       frame_valid_i,
  input  logic [1:0] hour_h_i,
  input  logic [3:0] hour_l_i,
  input  logic [2:0] minute_h_i,
  input  logic [3:0] minute_l_i,
  output logic       load_o,
  output logic [1:0] hour_h_o,
  output logic [3:0] hour_l_o,
  output logic [2:0] minute_h_o,
  output logic [3:0] minute_l_o,
  output logic       locked_o,
  output logic [1:0] state_o,
  output logic [3:0] miss_cnt_o
);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'd0,
    ST_CANDIDATE = 2'd1,
    ST_LOCKED    = 2'd2,
    ST_HOLDOVER  = 2'd3
  } state_e;

  localparam logic [4:0] MISS_LIMIT_W = 5'(MISS_LIMIT);

  // Time words are packed {hour_h[1:0], hour_l[3:0], minute_h[2:0], minute_l[3:0]}.

  // Next minute in BCD, wrapping 23:59 to 00:00.
  function automatic logic [12:0] succ(input logic [12:0] t);
    logic [1:0] hh;
    logic [3:0] hl;
    logic [2:0] mh;
    logic [3:0] ml;
    hh = t[12:11];
    hl = t[10:7];
    mh = t[6:4];
    ml = t[3:0];
    if (ml != 4'd9) begin
      ml = ml + 4'd1;
    end else begin
      ml = 4'd0;
      if (mh != 3'd5) begin
        mh = mh + 3'd1;
      end else begin
        mh = 3'd0;
        if (hh == 2'd2 && hl == 4'd3) begin
          hh = 2'd0;
          hl = 4'd0;
        end else if (hl == 4'd9) begin
          hl = 4'd0;
          hh = hh + 2'd1;
        end else begin
          hl = hl + 4'd1;
        end
      end
    end
    return {hh, hl, mh, ml};
  endfunction

  function automatic logic in_range(input logic [12:0] t);
    logic ok;
    ok = (t[12:11] <= 2'd2) && (t[10:7] <= 4'd9) &&
         (t[6:4] <= 3'd5)   && (t[3:0] <= 4'd9);
    // Hours 20..23 only: 24..29 are valid BCD digits but not a valid hour.
    if (t[12:11] == 2'd2 && t[10:7] > 4'd3) begin
      ok = 1'b0;
    end
    return ok;
  endfunction

  state_e      state_q, state_d;
  logic [12:0] ref_q, ref_d;
  logic [3:0]  miss_q, miss_d;
  logic        evald_q, evald_d;   // a frame has been evaluated in this window
  logic        acc_q, acc_d;       // this window has an accepted frame
  logic        load_q, load_d;
  logic [12:0] out_q, out_d;

  logic [12:0] w_frame;
  logic [12:0] w_expected;
  logic        w_good;
  logic        w_match;
  logic        w_mark;

  assign w_frame    = {hour_h_i, hour_l_i, minute_h_i, minute_l_i};
  assign w_expected = succ(ref_q);
  assign w_good     = in_range(w_frame);
  assign w_match    = w_good && (w_frame == w_expected);
  assign w_mark     = tick_i & minute_mark_i;

  // Frame evaluation happens first, then the window close sees its result, so
  // a frame coinciding with a mark counts towards the window being closed.
  always_comb begin
    state_d = state_q;
    ref_d   = ref_q;
    miss_d  = miss_q;
    evald_d = evald_q;
    acc_d   = acc_q;
    load_d  = 1'b0;
    out_d   = out_q;

    if (frame_valid_i && !evald_q) begin
      case (state_q)
        ST_UNLOCKED: begin
          if (w_good) begin
            ref_d   = w_frame;
            state_d = ST_CANDIDATE;
            evald_d = 1'b1;
          end
        end
        ST_CANDIDATE: begin
          evald_d = 1'b1;
          if (!w_good) begin
            state_d = ST_UNLOCKED;
          end else begin
            ref_d = w_frame;
            if (w_match) begin
              load_d  = 1'b1;
              out_d   = w_frame;
              acc_d   = 1'b1;
              state_d = ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          evald_d = 1'b1;
          if (w_match) begin
            ref_d  = w_frame;
            load_d = 1'b1;
            out_d  = w_frame;
            acc_d  = 1'b1;
          end
        end
        default: begin  // ST_HOLDOVER
          evald_d = 1'b1;
          if (w_match) begin
            ref_d   = w_frame;
            load_d  = 1'b1;
            out_d   = w_frame;
            acc_d   = 1'b1;
            miss_d  = 4'd0;
            state_d = ST_LOCKED;
          end
        end
      endcase
    end

    if (w_mark) begin
      case (state_d)
        ST_CANDIDATE: begin
          if (!evald_d) begin
            state_d = ST_UNLOCKED;
          end
        end
        ST_LOCKED, ST_HOLDOVER: begin
          if (!acc_d) begin
            // miss_d is 0 when LOCKED, so both states share the limit test.
            if (({1'b0, miss_d} + 5'd1) >= MISS_LIMIT_W) begin
              state_d = ST_UNLOCKED;
              miss_d  = 4'd0;
            end else begin
              ref_d   = succ(ref_d);
              miss_d  = miss_d + 4'd1;
              state_d = ST_HOLDOVER;
            end
          end
        end
        default: begin
        end
      endcase
      evald_d = 1'b0;
      acc_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_UNLOCKED;
      ref_q   <= '0;
      miss_q  <= '0;
      evald_q <= 1'b0;
      acc_q   <= 1'b0;
      load_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      ref_q   <= ref_d;
      miss_q  <= miss_d;
      evald_q <= evald_d;
      acc_q   <= acc_d;
      load_q  <= load_d;
      out_q   <= out_d;
    end
  end

  assign load_o     = load_q;
  assign hour_h_o   = out_q[12:11];
  assign hour_l_o   = out_q[10:7];
  assign minute_h_o = out_q[6:4];
  assign minute_l_o = out_q[3:0];
  assign locked_o   = state_q[1];
  assign state_o    = state_q;
  assign miss_cnt_o = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_msf_sync_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_msf_sync_ctrl
// Purpose  : Directed self-checking bench for msf_sync_ctrl (MISS_LIMIT = 3).
//            Observed vector: {load, hh, hl, mh, ml, state, miss}.
// Revision : 1.0 - initial release
// ============================================================================
module tb_msf_sync_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic       tick_i = 1'b0;
  logic       minute_mark_i = 1'b0;
  logic       frame_valid_i = 1'b0;
  logic [1:0] hour_h_i = '0;
  logic [3:0] hour_l_i = '0;
  logic [2:0] minute_h_i = '0;
  logic [3:0] minute_l_i = '0;
  logic       load_o;
  logic [1:0] hour_h_o;
  logic [3:0] hour_l_o;
  logic [2:0] minute_h_o;
  logic [3:0] minute_l_o;
  logic       locked_o;
  logic [1:0] state_o;
  logic [3:0] miss_cnt_o;

  int tests = 0;
  int fails = 0;

  msf_sync_ctrl #(.MISS_LIMIT(3)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .minute_mark_i(minute_mark_i),
    .frame_valid_i(frame_valid_i), .hour_h_i(hour_h_i), .hour_l_i(hour_l_i),
    .minute_h_i(minute_h_i), .minute_l_i(minute_l_i), .load_o(load_o),
    .hour_h_o(hour_h_o), .hour_l_o(hour_l_o), .minute_h_o(minute_h_o),
    .minute_l_o(minute_l_o), .locked_o(locked_o), .state_o(state_o),
    .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  logic [19:0] obs;
  assign obs = {load_o, hour_h_o, hour_l_o, minute_h_o, minute_l_o, state_o, miss_cnt_o};

  function automatic logic [19:0] ex(input logic l, input logic [1:0] hh, input logic [3:0] hl,
                                     input logic [2:0] mh, input logic [3:0] ml,
                                     input logic [1:0] st, input logic [3:0] ms);
    return {l, hh, hl, mh, ml, st, ms};
  endfunction

  // Stimulus primitives: drive on a falling edge, release on the next falling
  // edge; outputs are sampled by the caller at that second falling edge.
  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
  endtask

  task automatic frame(input logic [1:0] hh, input logic [3:0] hl, input logic [2:0] mh,
                       input logic [3:0] ml, input logic with_mark);
    @(negedge clk_i);
    hour_h_i = hh; hour_l_i = hl; minute_h_i = mh; minute_l_i = ml;
    frame_valid_i = 1'b1;
    tick_i = with_mark;
    minute_mark_i = with_mark;
    @(negedge clk_i);
    frame_valid_i = 1'b0;
    tick_i = 1'b0;
    minute_mark_i = 1'b0;
  endtask

  task automatic mark(input logic t, input logic m);
    @(negedge clk_i);
    tick_i = t;
    minute_mark_i = m;
    @(negedge clk_i);
    tick_i = 1'b0;
    minute_mark_i = 1'b0;
  endtask

  task automatic lock_1005();
    do_reset();
    frame(2'd1, 4'd0, 3'd0, 4'd4, 1'b0);
    mark(1'b1, 1'b1);
    frame(2'd1, 4'd0, 3'd0, 4'd5, 1'b0);
    mark(1'b1, 1'b1);
  endtask

  task automatic test_reset();
    logic [19:0] e;
    @(negedge clk_i);
    e = ex(0, 0, 0, 0, 0, 0, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL reset: got %h want %h", obs, e); end
    tests++; if (locked_o !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b want 0", locked_o); end
    rst_i = 1'b1;
  endtask

  task automatic test_lock();
    logic [19:0] e;
    frame(2'd1, 4'd2, 3'd3, 4'd4, 1'b0);
    e = ex(0, 0, 0, 0, 0, 1, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL lock_first: got %h want %h", obs, e); end
    mark(1'b1, 1'b1);
    frame(2'd1, 4'd2, 3'd3, 4'd5, 1'b0);
    e = ex(1, 1, 2, 3, 5, 2, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL lock_second: got %h want %h", obs, e); end
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL lock_locked: got %b want 1", locked_o); end
    @(negedge clk_i);
    tests++; if (load_o !== 1'b0) begin fails++; $display("FAIL lock_pulse_width: got %b want 0", load_o); end
  endtask

  task automatic test_rollover();
    logic [19:0] e;
    do_reset();
    frame(2'd2, 4'd3, 3'd5, 4'd7, 1'b0);
    mark(1'b1, 1'b1);
    frame(2'd2, 4'd3, 3'd5, 4'd8, 1'b0);
    mark(1'b1, 1'b1);
    frame(2'd2, 4'd3, 3'd5, 4'd9, 1'b0);
    e = ex(1, 2, 3, 5, 9, 2, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL roll_2359: got %h want %h", obs, e); end
    mark(1'b1, 1'b1);
    frame(2'd0, 4'd0, 3'd0, 4'd0, 1'b0);
    e = ex(1, 0, 0, 0, 0, 2, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL roll_0000: got %h want %h", obs, e); end
  endtask

  task automatic test_candidate();
    logic [19:0] e;
    do_reset();
    frame(2'd2, 4'd5, 3'd6, 4'd1, 1'b0);
    e = ex(0, 0, 0, 0, 0, 0, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL cand_bad: got %h want %h", obs, e); end
    mark(1'b1, 1'b1);
    frame(2'd0, 4'd7, 3'd0, 4'd0, 1'b0);
    tests++; if (state_o !== 2'd1) begin fails++; $display("FAIL cand_enter: got %0d want 1", state_o); end
    mark(1'b1, 1'b1);
    // Unhonoured mark and a lone tick must not close the empty window.
    mark(1'b0, 1'b1);
    mark(1'b1, 1'b0);
    tests++; if (state_o !== 2'd1) begin fails++; $display("FAIL cand_tick_only: got %0d want 1", state_o); end
    frame(2'd0, 4'd7, 3'd0, 4'd2, 1'b0);
    e = ex(0, 0, 0, 0, 0, 1, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL cand_replace: got %h want %h", obs, e); end
    mark(1'b1, 1'b1);
    frame(2'd0, 4'd7, 3'd0, 4'd3, 1'b0);
    e = ex(1, 0, 7, 0, 3, 2, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL cand_lock: got %h want %h", obs, e); end
    // Candidate window closing empty drops back to UNLOCKED.
    do_reset();
    frame(2'd0, 4'd1, 3'd0, 4'd0, 1'b0);
    mark(1'b1, 1'b1);
    mark(1'b1, 1'b1);
    tests++; if (state_o !== 2'd0) begin fails++; $display("FAIL cand_timeout: got %0d want 0", state_o); end
  endtask

  task automatic test_holdover();
    logic [19:0] e;
    lock_1005();
    e = ex(0, 1, 0, 0, 5, 2, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL hold_locked: got %h want %h", obs, e); end
    mark(1'b1, 1'b1);
    e = ex(0, 1, 0, 0, 5, 3, 1);
    tests++; if (obs !== e) begin fails++; $display("FAIL hold_miss1: got %h want %h", obs, e); end
    tests++; if (locked_o !== 1'b1) begin fails++; $display("FAIL hold_locked_o: got %b want 1", locked_o); end
    mark(1'b1, 1'b1);
    e = ex(0, 1, 0, 0, 5, 3, 2);
    tests++; if (obs !== e) begin fails++; $display("FAIL hold_miss2: got %h want %h", obs, e); end
    mark(1'b1, 1'b1);
    e = ex(0, 1, 0, 0, 5, 0, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL hold_unlock: got %h want %h", obs, e); end
  endtask

  task automatic test_recover();
    logic [19:0] e;
    lock_1005();
    mark(1'b1, 1'b1);
    frame(2'd1, 4'd0, 3'd0, 4'd7, 1'b0);
    e = ex(1, 1, 0, 0, 7, 2, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL recover_load: got %h want %h", obs, e); end
    lock_1005();
    mark(1'b1, 1'b1);
    frame(2'd1, 4'd0, 3'd0, 4'd6, 1'b0);
    e = ex(0, 1, 0, 0, 5, 3, 1);
    tests++; if (obs !== e) begin fails++; $display("FAIL recover_stale: got %h want %h", obs, e); end
    mark(1'b1, 1'b1);
    e = ex(0, 1, 0, 0, 5, 3, 2);
    tests++; if (obs !== e) begin fails++; $display("FAIL recover_next_mark: got %h want %h", obs, e); end
  endtask

  task automatic test_back_to_back();
    logic [19:0] e;
    lock_1005();
    frame(2'd1, 4'd0, 3'd0, 4'd6, 1'b1);
    e = ex(1, 1, 0, 0, 6, 2, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL same_cycle: got %h want %h", obs, e); end
    mark(1'b1, 1'b1);
    e = ex(0, 1, 0, 0, 6, 3, 1);
    tests++; if (obs !== e) begin fails++; $display("FAIL same_cycle_close: got %h want %h", obs, e); end
    // Second frame in an already-accepted window is ignored.
    lock_1005();
    frame(2'd1, 4'd0, 3'd0, 4'd6, 1'b0);
    frame(2'd1, 4'd0, 3'd0, 4'd7, 1'b0);
    e = ex(0, 1, 0, 0, 6, 2, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL dup_frame: got %h want %h", obs, e); end
    mark(1'b1, 1'b1);
    frame(2'd1, 4'd0, 3'd0, 4'd7, 1'b0);
    e = ex(1, 1, 0, 0, 7, 2, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL dup_next_window: got %h want %h", obs, e); end
  endtask

  task automatic test_async_reset();
    logic [19:0] e;
    do_reset();
    frame(2'd1, 4'd0, 3'd0, 4'd4, 1'b0);
    mark(1'b1, 1'b1);
    frame(2'd1, 4'd0, 3'd0, 4'd5, 1'b0);
    tests++; if (load_o !== 1'b1) begin fails++; $display("FAIL areset_pre: got %b want 1", load_o); end
    rst_i = 1'b0;
    #1;
    e = ex(0, 0, 0, 0, 0, 0, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL areset_clear: got %h want %h", obs, e); end
    @(negedge clk_i);
    rst_i = 1'b1;
    frame(2'd1, 4'd0, 3'd0, 4'd6, 1'b0);
    e = ex(0, 0, 0, 0, 0, 1, 0);
    tests++; if (obs !== e) begin fails++; $display("FAIL areset_relock: got %h want %h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_rollover();
    test_candidate();
    test_holdover();
    test_recover();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/msf_sync_ctrl.md
Name: msf_sync_ctrl

Overview:
- Lock/sequencing controller between time_date_decoder and digits.
- Qualifies decoded MSF minute frames before they load the displayed time: requires two consecutive frames one minute apart to lock.
- Once locked, re-syncs on matching frames and free-runs through bad or missing frames for a bounded number of minutes before unlocking.
- Drives the digits load strobe and load values.

Parameters:
MISS_LIMIT, 3, consecutive unaccepted minute windows tolerated in HOLDOVER before returning to UNLOCKED (range 1..15)

Ports:
clk_i  input  1  system clock
rst_i  input  1  asynchronous active-low reset
tick_i  input  1  one-cycle pulse per decoded second (decoder bits_valid)
minute_mark_i  input  1  one-cycle pulse at second 00; only honoured when tick_i=1
frame_valid_i  input  1  one-cycle pulse: decoded frame fields valid (time_date_decoder valid)
hour_h_i  input  2  decoded hour tens, BCD
hour_l_i  input  4  decoded hour units, BCD
minute_h_i  input  3  decoded minute tens, BCD
minute_l_i  input  4  decoded minute units, BCD
load_o  output  1  one-cycle strobe to digits load
hour_h_o  output  2  hour tens to load
hour_l_o  output  4  hour units to load
minute_h_o  output  3  minute tens to load
minute_l_o  output  4  minute units to load
locked_o  output  1  1 in LOCKED or HOLDOVER
state_o  output  2  0 UNLOCKED, 1 CANDIDATE, 2 LOCKED, 3 HOLDOVER
miss_cnt_o  output  4  current consecutive-miss count

Behaviour:
- Reset (rst_i=0, async): state UNLOCKED; all outputs 0; ref register 00:00; miss 0; window flags clear.
- Range check: frame is in range iff hour_h<=2, hour_l<=9, hour<=23, minute_h<=5, minute_l<=9. A frame out of range is "bad".
- Successor function succ(t):
  - Minute units 9->0 with tens carry; tens 5->0 with hour carry.
  - Hour units 9->0 with tens carry; 23:59 -> 00:00.
- ref: last accepted or predicted time. expected = succ(ref).
- Minute window: the interval closed by each honoured minute mark. A frame_valid_i in the same cycle as a mark is evaluated first and belongs to the closing window.
- UNLOCKED:
  - Good frame -> ref<=frame; go to CANDIDATE.
  - Bad frame -> ignored.
  - Minute marks ignored.
- CANDIDATE:
  - Good frame equal to expected -> ref<=frame; load_o pulse; go to LOCKED.
  - Good frame not equal to expected -> ref<=frame; stay in CANDIDATE.
  - Bad frame -> UNLOCKED.
  - Window closes with no frame -> UNLOCKED.
- LOCKED:
  - Frame equal to expected -> ref<=frame; load_o pulse; window accepted.
  - Mismatch or bad frame -> window marked not accepted; no load.
  - Window closes not accepted -> ref<=succ(ref); miss<=1; go to HOLDOVER.
- HOLDOVER:
  - Frame equal to expected -> ref<=frame; load_o; miss<=0; go to LOCKED.
  - Window closes not accepted -> ref<=succ(ref); miss<=miss+1.
  - When miss+1 reaches MISS_LIMIT -> UNLOCKED, miss<=0.
- Only one frame is evaluated per window. Further frame_valid_i pulses in a window that is already accepted are ignored.
- load_o and the hour/minute outputs are registered; they assert 1 cycle after the accepting frame_valid_i.
- The hour/minute outputs hold the last loaded value between loads. In HOLDOVER they hold the last loaded value, not ref.
- tick_i without minute_mark_i has no effect on state. The block is purely event-driven on marks and frames.
- A reset mid-operation clears everything immediately; the next lock again needs two frames.

Test Plan:
1. Reset, then frames 12:34 and 12:35 in successive windows -> no load after the first; load_o pulse 1 cycle after the second with outputs 1,2,3,5; state 2; locked_o=1.
2. Lock at 23:58, then frame 23:59, then frame 00:00 -> two loads, the second with outputs 0,0,0,0; state stays 2.
3. UNLOCKED, frame 25:61 -> state stays 0, no load. Then frames 07:00, 07:02, 07:03 -> state goes 1, then stays 1 (candidate replaced by 07:02), then load 07:03 and state 2.
4. Locked at 10:05, MISS_LIMIT=3, three marks with no frames -> state 3 with miss 1, then miss 2, then state 0 with miss 0; no loads.
5. Locked at 10:05, one empty window, then frame 10:07 -> load 10:07; state 2; miss 0. A frame of 10:06 instead -> no load; miss stays 1 until the next mark.
6. Frame_valid_i and minute_mark_i in the same cycle while LOCKED with a matching frame -> load, no miss. Async reset asserted during load_o -> all outputs 0 within the same cycle.
